// File: rtl/elevator_car_model.sv
// Single-car elevator model: four floors, timed travel between floors, timed door opening,
// and a sticky flag for protocol violations. Every output is a decode of registered state.
module elevator_car_model #(
  parameter int unsigned TRAVEL_CYCLES = 8,
  parameter int unsigned DOOR_CYCLES   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] AC,
  input  logic       open,
  output logic       S1,
  output logic       S2,
  output logic       S3,
  output logic       S4,
  output logic [1:0] pos,
  output logic       moving,
  output logic       door_open,
  output logic       fault
);

  typedef enum logic [1:0] {
    AT_FLOOR    = 2'd0,
    TRAVEL_UP   = 2'd1,
    TRAVEL_DOWN = 2'd2,
    DOOR        = 2'd3
  } state_t;

  localparam logic [1:0] AC_STOP = 2'b00;
  localparam logic [1:0] AC_UP   = 2'b01;
  localparam logic [1:0] AC_BAD  = 2'b10;
  localparam logic [1:0] AC_DOWN = 2'b11;

  localparam logic [7:0] TC_LAST = 8'(TRAVEL_CYCLES - 1);
  localparam logic [7:0] DC_MAX  = 8'(DOOR_CYCLES);

  state_t     r_state;
  logic [1:0] r_pos;
  logic [7:0] r_tcnt;
  logic [7:0] r_dcnt;
  logic       r_fault;

  logic w_level;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= AT_FLOOR;
      r_pos   <= '0;
      r_tcnt  <= '0;
      r_dcnt  <= '0;
      r_fault <= 1'b0;
    end else begin
      // The illegal motor code is flagged in every state; below it behaves like a stop command.
      if (AC == AC_BAD) r_fault <= 1'b1;

      case (r_state)
        AT_FLOOR: begin
          if (open) begin
            r_state <= DOOR;
            r_dcnt  <= '0;
          end else if (AC == AC_UP) begin
            if (r_pos != 2'd3) begin
              r_state <= TRAVEL_UP;
              r_tcnt  <= '0;
            end else begin
              r_fault <= 1'b1;
            end
          end else if (AC == AC_DOWN) begin
            if (r_pos != 2'd0) begin
              r_state <= TRAVEL_DOWN;
              r_tcnt  <= '0;
            end else begin
              r_fault <= 1'b1;
            end
          end
        end

        TRAVEL_UP: begin
          if (AC != AC_UP || open) r_fault <= 1'b1;
          if (r_tcnt == TC_LAST) begin
            r_pos   <= r_pos + 2'd1;
            r_tcnt  <= '0;
            r_state <= AT_FLOOR;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end

        TRAVEL_DOWN: begin
          if (AC != AC_DOWN || open) r_fault <= 1'b1;
          if (r_tcnt == TC_LAST) begin
            r_pos   <= r_pos - 2'd1;
            r_tcnt  <= '0;
            r_state <= AT_FLOOR;
          end else begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end

        DOOR: begin
          if (AC != AC_STOP) r_fault <= 1'b1;
          if (!open) begin
            r_state <= AT_FLOOR;
          end else if (r_dcnt != DC_MAX) begin
            r_dcnt <= r_dcnt + 8'd1;
          end
        end

        default: r_state <= AT_FLOOR;
      endcase
    end
  end

  assign w_level   = (r_state == AT_FLOOR) || (r_state == DOOR);
  assign S1        = w_level && (r_pos == 2'd0);
  assign S2        = w_level && (r_pos == 2'd1);
  assign S3        = w_level && (r_pos == 2'd2);
  assign S4        = w_level && (r_pos == 2'd3);
  assign pos       = r_pos;
  assign moving    = (r_state == TRAVEL_UP) || (r_state == TRAVEL_DOWN);
  assign door_open = (r_state == DOOR) && (r_dcnt == DC_MAX);
  assign fault     = r_fault;

endmodule

// File: tb/tb_elevator_car_model.sv
// Directed bench for elevator_car_model using TRAVEL_CYCLES=8 and DOOR_CYCLES=4.
// The expected output vectors below were worked out by hand.
module tb_elevator_car_model;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] AC;
  logic       open;
  logic       S1, S2, S3, S4;
  logic [1:0] pos;
  logic       moving, door_open, fault;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // Observed vector layout: {S4,S3,S2,S1, pos[1:0], moving, door_open, fault}
  logic [8:0] w_obs;
  assign w_obs = {S4, S3, S2, S1, pos, moving, door_open, fault};

  elevator_car_model #(
    .TRAVEL_CYCLES(8),
    .DOOR_CYCLES  (4)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .AC       (AC),
    .open     (open),
    .S1       (S1),
    .S2       (S2),
    .S3       (S3),
    .S4       (S4),
    .pos      (pos),
    .moving   (moving),
    .door_open(door_open),
    .fault    (fault)
  );

  always #5 clk = ~clk;

  task automatic step(input int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [8:0] exp);
    checks++;
    assert (w_obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, w_obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    AC    = 2'b00;
    open  = 1'b0;
    step(2);
    chk("reset_state", 9'b0001_00_0_0_0);

    // Hold AC up from floor 1: the car should go all the way to floor 4.
    reset = 1'b0;
    AC    = 2'b01;
    step(1);                                   // edge k
    chk("depart_f1", 9'b0000_00_1_0_0);
    step(7);                                   // k+7
    chk("in_travel_k7", 9'b0000_00_1_0_0);
    step(1);                                   // k+8
    chk("arrive_f2", 9'b0010_01_0_0_0);
    step(1);                                   // k+9
    chk("depart_f2", 9'b0000_01_1_0_0);
    step(8);                                   // k+17
    chk("arrive_f3", 9'b0100_10_0_0_0);
    step(9);                                   // k+26
    chk("arrive_f4", 9'b1000_11_0_0_0);
    step(1);                                   // AC up at the top floor
    chk("up_at_top", 9'b1000_11_0_0_1);

    reset = 1'b1;
    AC    = 2'b00;
    #1;
    chk("reset_from_top", 9'b0001_00_0_0_0);
    step(1);
    reset = 1'b0;

    // Go to floor 2, then run the door sequence there.
    AC = 2'b01;
    step(1);
    step(8);
    AC = 2'b00;
    step(1);
    chk("park_f2", 9'b0010_01_0_0_0);
    open = 1'b1;
    step(1);                                   // edge k: enter DOOR
    chk("door_enter", 9'b0010_01_0_0_0);
    step(3);                                   // k+3
    chk("door_k3", 9'b0010_01_0_0_0);
    step(1);                                   // k+4
    chk("door_open_k4", 9'b0010_01_0_1_0);
    AC = 2'b11;
    step(1);
    chk("down_in_door", 9'b0010_01_0_1_1);
    step(2);
    chk("door_no_motion", 9'b0010_01_0_1_1);
    AC   = 2'b00;
    open = 1'b0;
    step(1);
    chk("door_close", 9'b0010_01_0_0_1);
    step(1);
    chk("idle_after_door", 9'b0010_01_0_0_1);

    reset = 1'b1;
    #1;
    chk("reset_from_f2", 9'b0001_00_0_0_0);
    step(1);
    reset = 1'b0;

    // Send conflicting commands during travel: the arrival time must stay the same.
    AC = 2'b01;
    step(1);                                   // edge k
    step(3);                                   // k+3
    open = 1'b1;
    step(1);                                   // k+4
    chk("open_mid_travel", 9'b0000_00_1_0_1);
    open = 1'b0;
    AC   = 2'b11;
    step(1);                                   // k+5
    chk("down_mid_travel", 9'b0000_00_1_0_1);
    AC = 2'b01;
    step(2);                                   // k+7
    chk("still_travel_k7", 9'b0000_00_1_0_1);
    step(1);                                   // k+8
    chk("arrive_f2_faulted", 9'b0010_01_0_0_1);
    step(6);                                   // k+14: next departure was at k+9, tcnt=5
    chk("mid_f2_f3", 9'b0000_01_1_0_1);
    reset = 1'b1;
    #1;
    chk("async_reset_mid", 9'b0001_00_0_0_0);
    AC = 2'b00;
    step(1);
    reset = 1'b0;
    step(1);
    chk("idle_after_reset", 9'b0001_00_0_0_0);

    // Illegal motor code, then AC down at the bottom floor.
    AC = 2'b10;
    step(1);
    chk("illegal_ac", 9'b0001_00_0_0_1);
    reset = 1'b1;
    AC    = 2'b00;
    step(1);
    reset = 1'b0;
    AC    = 2'b11;
    step(1);
    chk("down_at_bottom", 9'b0001_00_0_0_1);
    AC = 2'b00;
    step(1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
